// File: rtl/spi_master_tx.sv
// Mode-0 SPI master: shifts a WIDTH-bit frame out on MOSI MSB first and collects MISO into rx_data.
// Latency: SSEL falls one cycle after start; done arrives SETUP+(2*WIDTH-1)*HALF+HOLD+1 cycles later.
// Backpressure: none; start is taken only while busy=0, and a start seen while busy is dropped.
// Ports: clk/rst_n clock and async active-low reset; start/tx_data request and frame;
//        busy/done/rx_data status and captured frame; SCK/SSEL/MOSI/MISO the SPI pins.
module spi_master_tx #(
   parameter int WIDTH     = 88,
   parameter int HALF_CYC  = 8,
   parameter int SETUP_CYC = 8,
   parameter int HOLD_CYC  = 8,
   parameter int GAP_CYC   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] tx_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rx_data,
   output logic             SCK,
   output logic             SSEL,
   output logic             MOSI,
   input  logic             MISO
);

   localparam int M1   = (HALF_CYC > SETUP_CYC) ? HALF_CYC : SETUP_CYC;
   localparam int M2   = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
   localparam int MAXC = (M1 > M2) ? M1 : M2;
   localparam int PW   = $clog2(MAXC + 1);
   localparam int BW   = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    ph_q, ph_d;       // cycles left in the current phase, minus one
   logic [BW-1:0]    bit_q, bit_d;     // SCK high phases still to come, this one included
   logic [WIDTH-1:0] tx_q, tx_d;
   logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [WIDTH-1:0] rx_q, rx_d;
   logic             sck_q, sck_d;
   logic             ssel_q, ssel_d;
   logic             mosi_q, mosi_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             miso_s1_q, miso_s2_q;

   logic             ph_last;
   logic [WIDTH-1:0] tx_shift;
   logic [WIDTH-1:0] rx_shift;

   assign ph_last  = (ph_q == '0);
   // Shift expressions avoid part-selects so WIDTH=1 still elaborates.
   assign tx_shift = tx_q << 1;
   assign rx_shift = (rx_sh_q << 1) | WIDTH'(miso_s2_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miso_s1_q <= 1'b0;
         miso_s2_q <= 1'b0;
      end else begin
         miso_s1_q <= MISO;
         miso_s2_q <= miso_s1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ph_q    <= '0;
         bit_q   <= '0;
         tx_q    <= '0;
         rx_sh_q <= '0;
         rx_q    <= '0;
         sck_q   <= 1'b0;
         ssel_q  <= 1'b1;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         rx_sh_q <= rx_sh_d;
         rx_q    <= rx_d;
         sck_q   <= sck_d;
         ssel_q  <= ssel_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Pin outputs are computed one cycle early so SCK/SSEL/MOSI change on the
   // same edge as the state they belong to.
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_sh_d = rx_sh_q;
      rx_d    = rx_q;
      sck_d   = sck_q;
      ssel_d  = ssel_q;
      mosi_d  = mosi_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (state_q != IDLE && !ph_last) begin
         ph_d = ph_q - 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               tx_d    = tx_data;
               bit_d   = BW'(WIDTH);
               ph_d    = PW'(SETUP_CYC - 1);
               busy_d  = 1'b1;
               ssel_d  = 1'b0;
               mosi_d  = tx_data[WIDTH-1];
               state_d = SETUP;
            end
         end
         SETUP, LOW: begin
            // Final cycle before a rising edge: the slave's bit has settled.
            if (ph_last) begin
               rx_sh_d = rx_shift;
               ph_d    = PW'(HALF_CYC - 1);
               sck_d   = 1'b1;
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (ph_last) begin
               bit_d = bit_q - 1'b1;
               sck_d = 1'b0;
               if (bit_q == BW'(1)) begin
                  ph_d    = PW'(HOLD_CYC - 1);
                  state_d = HOLD;
               end else begin
                  tx_d    = tx_shift;
                  mosi_d  = tx_shift[WIDTH-1];
                  ph_d    = PW'(HALF_CYC - 1);
                  state_d = LOW;
               end
            end
         end
         HOLD: begin
            if (ph_last) begin
               ssel_d  = 1'b1;
               rx_d    = rx_sh_q;
               done_d  = 1'b1;
               ph_d    = PW'(GAP_CYC - 1);
               state_d = GAP;
            end
         end
         GAP: begin
            if (ph_last) begin
               busy_d  = 1'b0;
               mosi_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_q;
   assign SCK     = sck_q;
   assign SSEL    = ssel_q;
   assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master_tx.sv
`timescale 1ns/1ps
module tb_spi_master_tx;
   localparam int W  = 8;
   localparam int H  = 4;
   localparam int S  = 4;
   localparam int HO = 4;
   localparam int G  = 4;
   localparam int L  = S + (2*W-1)*H + HO;
   localparam logic [87:0] SLV_TX = {8'h5A, 80'hFEDCBA9876543210FEDC};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic start_a = 1'b0;
   logic [W-1:0] tx_a = '0;
   logic busy_a, done_a, SCK_a, SSEL_a, MOSI_a, miso_a;
   logic [W-1:0] rx_a;
   logic miso_one = 1'b0;
   assign miso_a = miso_one ? 1'b1 : MOSI_a;

   spi_master_tx #(.WIDTH(W), .HALF_CYC(H), .SETUP_CYC(S), .HOLD_CYC(HO), .GAP_CYC(G)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_a), .busy(busy_a), .done(done_a),
      .rx_data(rx_a), .SCK(SCK_a), .SSEL(SSEL_a), .MOSI(MOSI_a), .MISO(miso_a));

   logic start_b = 1'b0;
   logic [87:0] tx_b = '0;
   logic busy_b, done_b, SCK_b, SSEL_b, MOSI_b;
   logic miso_b = 1'b0;
   logic [87:0] rx_b;

   spi_master_tx dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_b), .busy(busy_b), .done(done_b),
      .rx_data(rx_b), .SCK(SCK_b), .SSEL(SSEL_b), .MOSI(MOSI_b), .MISO(miso_b));

   // Behavioural slave for the full-size instance.
   logic [87:0] s_out = '0;
   logic [87:0] s_rx  = '0;
   always @(negedge SSEL_b) begin
      s_out  = SLV_TX;
      miso_b = s_out[87];
   end
   always @(posedge SCK_b) begin
      s_rx = {s_rx[86:0], MOSI_b};
      #13;
      s_out  = s_out << 1;
      miso_b = s_out[87];
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Frame model: k counts cycles since the accepting edge.
   logic         m_active = 1'b0;
   int           m_k = 0;
   logic [W-1:0] m_tx = '0;
   logic [W-1:0] m_rx = '0;

   function automatic logic [4:0] exp_pins(input int k, input logic act, input logic [W-1:0] tx);
      logic sck, ssel, mosi, bsy, dn;
      int j, p, b;
      sck = 1'b0; ssel = 1'b1; mosi = 1'b0; bsy = 1'b0; dn = 1'b0;
      if (act) begin
         bsy  = 1'b1;
         ssel = (k > L);
         dn   = (k == L + 1);
         if (k <= S) begin
            mosi = tx[W-1];
         end else if (k <= S + (2*W-1)*H) begin
            j = k - S - 1;
            p = j / H;
            sck = (p % 2 == 0);
            b = (p + 1) / 2;
            mosi = tx[W-1-b];
         end else begin
            mosi = tx[0];
         end
      end
      return {sck, ssel, mosi, bsy, dn};
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_rx = '0;
      end else begin
         if (!m_active && start_a) begin
            m_active = 1'b1;
            m_k = 1;
            m_tx = tx_a;
         end else if (m_active) begin
            m_k++;
            if (m_k > L + G) m_active = 1'b0;
         end
         if (m_active && m_k == L + 1) m_rx = miso_one ? '1 : m_tx;
      end
   end

   // Monitors for the directed checks.
   int ssel_low = 0, rises = 0, done_cnt = 0, done_at_rise = 0, viol = 0;
   logic [W-1:0] mosi_rise = '0;
   logic sck_prev = 1'b0, ssel_prev = 1'b1, mosi_prev = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_rx = '0;
      end
      check("cycle", {SCK_a, SSEL_a, MOSI_a, busy_a, done_a, rx_a},
            {exp_pins(m_k, m_active, m_tx), m_rx});
      if (!SSEL_a) ssel_low++;
      if (SCK_a && !sck_prev) begin
         rises++;
         mosi_rise = {mosi_rise[W-2:0], MOSI_a};
      end
      if (done_a) done_cnt++;
      if (done_a && SSEL_a && !ssel_prev) done_at_rise++;
      if (SCK_a && sck_prev && MOSI_a != mosi_prev) viol++;
      sck_prev = SCK_a;
      ssel_prev = SSEL_a;
      mosi_prev = MOSI_a;
   end

   task automatic clr_mon();
      ssel_low = 0; rises = 0; done_cnt = 0; done_at_rise = 0; viol = 0; mosi_rise = '0;
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while ((busy_a || m_active) && n < 400) begin
         @(posedge clk); #2;
         n++;
      end
      total++;
      if (n >= 400) begin
         bad++;
         $display("FAIL %s timeout got=busy want=idle", nm);
      end
   endtask

   task automatic run_frame(input logic [W-1:0] d, input logic one);
      miso_one = one;
      clr_mon();
      tx_a = d;
      start_a = 1'b1;
      @(posedge clk); #2;
      start_a = 1'b0;
      wait_idle("frame");
   endtask

   task automatic wait_gap_end();
      int n;
      n = 0;
      while (!(m_active && m_k == L + G) && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      check("gap_end_found", (n < 200), 1);
   endtask

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Idle after reset.
      repeat (20) @(posedge clk);
      #2;
      check("idle_pins", {SCK_a, SSEL_a, MOSI_a, busy_a, done_a, rx_a}, {5'b01000, 8'h00});
      check("idle_b", {SCK_b, SSEL_b, MOSI_b, busy_b, done_b}, 5'b01000);

      // Loopback frame.
      run_frame(8'hA5, 1'b0);
      check("t2_ssel_low", ssel_low, 68);
      check("t2_rises", rises, 8);
      check("t2_mosi_bits", mosi_rise, 8'hA5);
      check("t2_done_at_rise", done_at_rise, 1);
      check("t2_rx", rx_a, 8'hA5);

      // MISO tied high.
      run_frame(8'h3C, 1'b1);
      check("t3_rx", rx_a, 8'hFF);
      check("t3_mosi_bits", mosi_rise, 8'h3C);
      check("t3_mosi_stable", viol, 0);

      // Starts while busy are ignored.
      miso_one = 1'b0;
      clr_mon();
      tx_a = 8'h5A; start_a = 1'b1;
      @(posedge clk); #2 start_a = 1'b0;
      repeat (20) @(posedge clk);
      #2 tx_a = 8'hFF; start_a = 1'b1;
      @(posedge clk); #2 start_a = 1'b0;
      wait_gap_end();
      start_a = 1'b1;
      @(posedge clk); #2 start_a = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      check("t4_done_once", done_cnt, 1);
      check("t4_rises", rises, 8);
      check("t4_no_restart", busy_a, 0);
      check("t4_rx", rx_a, 8'h5A);
      // A start held across the falling edge of busy starts the next frame.
      clr_mon();
      tx_a = 8'h81; start_a = 1'b1;
      @(posedge clk); #2 start_a = 1'b0;
      wait_gap_end();
      tx_a = 8'hC3; start_a = 1'b1;
      @(posedge clk); #2;
      @(posedge clk); #2 start_a = 1'b0;
      check("t4_restarted", busy_a, 1);
      wait_idle("t4_second");
      check("t4_two_frames", done_cnt, 2);
      check("t4_rx2", rx_a, 8'hC3);

      // Reset during bit 3.
      clr_mon();
      tx_a = 8'h96; start_a = 1'b1;
      @(posedge clk); #2 start_a = 1'b0;
      n = 0;
      while (rises < 3 && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      check("t5_reached_bit3", rises, 3);
      rst_n = 1'b0;
      #1;
      check("t5_pins_reset", {SCK_a, SSEL_a, busy_a}, 3'b010);
      @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      check("t5_no_done", done_cnt, 0);
      run_frame(8'h69, 1'b0);
      check("t5_clean_rises", rises, 8);
      check("t5_clean_ssel", ssel_low, 68);
      check("t5_clean_rx", rx_a, 8'h69);

      // Full-size instance against the slave model.
      tx_b = 88'h0123456789ABCDEF012345;
      start_b = 1'b1;
      @(posedge clk); #2 start_b = 1'b0;
      n = 0;
      while (!done_b && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("t6_done_seen", done_b, 1);
      check("t6_slave_rx", s_rx, 88'h0123456789ABCDEF012345);
      check("t6_rx_top", rx_b[87:80], 8'h5A);
      check("t6_rx_full", rx_b, SLV_TX);
      n = 0;
      while (busy_b && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      check("t6_idle", {busy_b, SSEL_b, SCK_b, MOSI_b}, 4'b0100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
